// File: rtl/hs_dpath_vld_chain_if.sv
// ============================================================================
// Module : hs_dpath_vld_chain_if
// Brief  : Handshake, flush and stage-enable bundle for hs_dpath_vld_chain.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hs_dpath_vld_chain_if #(
  parameter int LATENCY = 1
);
  localparam int OCC_W = $clog2(LATENCY + 1);

  logic               in_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic               flush;
  logic [LATENCY-1:0] stage_ce;
  logic [LATENCY:0]   vld_tap;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output in_valid, out_ready, flush,
    input  in_ready, out_valid, stage_ce, vld_tap, occupancy
  );

  modport slave (
    input  in_valid, out_ready, flush,
    output in_ready, out_valid, stage_ce, vld_tap, occupancy
  );
endinterface

`default_nettype wire

// File: rtl/hs_dpath_vld_chain.sv
// ============================================================================
// Module : hs_dpath_vld_chain
// Brief  : Valid-token chain producing per-stage clock enables for an N-stage
//          datapath with backpressure, flush and occupancy counting.
//          Define HS_DPATH_VLD_CHAIN_COLLAPSE_EN for bubble-collapsing enables.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hs_dpath_vld_chain #(
  parameter int LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   aresetn,
  hs_dpath_vld_chain_if.slave    bus
);
  localparam int OCC_W = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] en;
  logic [OCC_W-1:0]   occ_q;
  logic [OCC_W-1:0]   occ_nxt;
  logic               in_rdy;
  logic               out_vld;
  logic               in_fire;
  logic               out_fire;

`ifdef HS_DPATH_VLD_CHAIN_COLLAPSE_EN
  // A stage may load when it is empty or its token moves on downstream.
  always_comb begin : p_en
    logic adv;
    adv = bus.out_ready;
    en  = '0;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      en[i] = ~vld[i] | adv;
      adv   = en[i];
    end
  end
`else
  logic stall_n;
  assign stall_n = ~vld[LATENCY-1] | bus.out_ready;
  assign en      = {LATENCY{stall_n}};
`endif

  assign in_rdy   = en[0] & ~bus.flush;
  assign out_vld  = vld[LATENCY-1] & ~bus.flush;
  assign in_fire  = bus.in_valid & in_rdy;
  assign out_fire = out_vld & bus.out_ready;

  always_comb begin
    occ_nxt = occ_q;
    if (in_fire && !out_fire) begin
      occ_nxt = occ_q + OCC_W'(1);
    end else if (!in_fire && out_fire) begin
      occ_nxt = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld   <= '0;
      occ_q <= '0;
    end else if (bus.flush) begin
      vld   <= '0;
      occ_q <= '0;
    end else begin
      if (en[0]) begin
        vld[0] <= bus.in_valid;
      end
      for (int i = 1; i < LATENCY; i++) begin
        if (en[i]) begin
          vld[i] <= vld[i-1];
        end
      end
      occ_q <= occ_nxt;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.stage_ce  = en & {LATENCY{~bus.flush}};
  assign bus.vld_tap   = {vld, in_fire};
  assign bus.occupancy = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_hs_dpath_vld_chain.sv
// ============================================================================
// Module : tb_hs_dpath_vld_chain
// Brief  : Token-position reference model plus in-order scoreboard, checking
//          LATENCY=4 and LATENCY=1 chains under directed and random traffic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hs_dpath_vld_chain;
  typedef struct {
    int id;
    int pos;
    int acc;
  } tok_t;

  logic clk       = 1'b0;
  logic aresetn   = 1'b0;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  logic flush     = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   next_id   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    localparam int L = (d == 0) ? 4 : 1;

    hs_dpath_vld_chain_if #(.LATENCY(L)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.out_ready = out_ready;
    assign bus.flush     = flush;

    hs_dpath_vld_chain #(.LATENCY(L)) u_dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus.slave)
    );

    // Model: queue of tokens, oldest first, each with its stage position.
    tok_t toks[$];
    int   sb_id[$];
    int   sb_acc[$];

    always @(negedge clk) begin : p_check
      bit         mv [L];
      bit         g, ir, ov, ifire, ofire;
      logic [L-1:0] ce;
      logic [L:0]   tap;
      int         n, pid, pacc, exp_id;
      tok_t       t;
      string      tag;
      tag = $sformatf("L%0d", L);
      if (!aresetn) begin
        chk({tag, " rst_out_valid"}, longint'(bus.out_valid), 0);
        chk({tag, " rst_in_ready"}, longint'(bus.in_ready), 1);
        chk({tag, " rst_occupancy"}, longint'(bus.occupancy), 0);
        chk({tag, " rst_vld_tap"}, longint'(bus.vld_tap[L:1]), 0);
        toks.delete();
        sb_id.delete();
        sb_acc.delete();
      end else begin
        n = toks.size();
        g = (n == 0) || (toks[0].pos < L - 1) || out_ready;
        for (int k = 0; k < L; k++) mv[k] = 1'b0;
        for (int k = 0; k < n; k++) begin
`ifdef HS_DPATH_VLD_CHAIN_COLLAPSE_EN
          if (k == 0) mv[k] = (toks[k].pos < L - 1) || out_ready;
          else        mv[k] = (toks[k].pos + 1 < toks[k-1].pos) || mv[k-1];
`else
          mv[k] = g;
`endif
        end
`ifdef HS_DPATH_VLD_CHAIN_COLLAPSE_EN
        ir = (n == 0) || (toks[n-1].pos > 0) || mv[n-1];
        ce = '1;
        for (int k = 0; k < n; k++) ce[toks[k].pos] = mv[k];
`else
        ir = g;
        ce = {L{g}};
`endif
        ir    = ir && !flush;
        ce    = flush ? '0 : ce;
        ov    = (n > 0) && (toks[0].pos == L - 1) && !flush;
        ifire = in_valid && ir;
        ofire = ov && out_ready;
        tap   = '0;
        tap[0] = ifire;
        for (int k = 0; k < n; k++) tap[toks[k].pos + 1] = 1'b1;

        chk({tag, " in_ready"}, longint'(bus.in_ready), longint'(ir));
        chk({tag, " out_valid"}, longint'(bus.out_valid), longint'(ov));
        chk({tag, " stage_ce"}, longint'(bus.stage_ce), longint'(ce));
        chk({tag, " vld_tap"}, longint'(bus.vld_tap), longint'(tap));
        chk({tag, " occupancy"}, longint'(bus.occupancy), longint'(n));

        if (bus.out_valid && out_ready) begin
          if (sb_id.size() == 0) begin
            chk({tag, " sb_underflow"}, 1, 0);
          end else begin
            pid    = sb_id.pop_front();
            pacc   = sb_acc.pop_front();
            exp_id = ofire ? toks[0].id : -1;
            chk({tag, " token_order"}, pid, exp_id);
            chk({tag, " latency_min"}, longint'(cyc - pacc >= L), 1);
          end
        end

        if (flush) begin
          toks.delete();
          sb_id.delete();
          sb_acc.delete();
        end else begin
          for (int k = 0; k < n; k++) begin
            if (mv[k]) begin
              t = toks[k];
              t.pos = t.pos + 1;
              toks[k] = t;
            end
          end
          if (ofire) void'(toks.pop_front());
          if (ifire) begin
            t.id  = next_id;
            t.pos = 0;
            t.acc = cyc;
            toks.push_back(t);
            sb_id.push_back(next_id);
            sb_acc.push_back(cyc);
            next_id++;
          end
        end
      end
    end
  end

  task automatic drive(input bit iv, input bit ordy, input bit fl, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2;
    flush   = 1'b0;
    aresetn = 1'b0;
    @(posedge clk);
    #2;
    aresetn = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 aresetn = 1'b1;
    // Continuous streaming from reset
    drive(1, 1, 0, 12);
    // Fill to three tokens, then flush with in_valid and out_ready high
    drive(0, 0, 1, 1);
    drive(1, 0, 0, 3);
    drive(1, 1, 1, 1);
    drive(0, 1, 0, 2);
    // Sparse input under backpressure, then sustained input
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 6);
    // Full chain with simultaneous in/out fire
    drive(1, 1, 0, 6);
    // Two tokens in flight, then asynchronous reset
    drive(0, 0, 1, 1);
    drive(1, 0, 0, 2);
    reset_pulse();
    drive(1, 1, 0, 4);
    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_pulse();
      end else begin
        drive($urandom_range(0, 3) != 0,
              ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
              $urandom_range(0, 59) == 0, 1);
      end
    end
    drive(0, 1, 0, 8);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hs_dpath_vld_chain.md
# hs_dpath_vld_chain

Parameterised valid-token chain that generates per-stage clock enables for an N-stage datapath pipeline with ready/valid backpressure, synchronous flush and an occupancy counter. It generalises the plain CE shift chain: tokens stall in place under backpressure instead of free-running. Bubbles collapse when the feature is compiled in. It sits beside any `hs_dpath_*` register pipeline and drives that pipeline's per-stage `ce` inputs.

## Interface
- `LATENCY`, 1, number of pipeline stages (1..65535)
- `OCC_W`, `$clog2(LATENCY+1)`, occupancy counter width (derived, not overridden)
- `clk` in 1: clock; all state updates on the rising edge
- `aresetn` in 1: asynchronous active-low reset
- `in_valid` in 1: upstream token present
- `in_ready` out 1: chain accepts the token this cycle
- `out_valid` out 1: token present at the last stage
- `out_ready` in 1: downstream consumes the token
- `flush` in 1: synchronous discard of all tokens
- `stage_ce` out [LATENCY]: load enable for datapath stage i
- `vld_tap` out [LATENCY+1]: [0] = input fire, [i] = valid of stage i-1
- `occupancy` out OCC_W: number of valid stages

## Operation
- State consists of `vld[0..LATENCY-1]` (stage valid flags) and the `occupancy` register.
- `out_valid = vld[LATENCY-1] & ~flush`.
- `adv[LATENCY] = out_ready`.
- Stage enable with bubble collapse:
  - `en[i] = ~vld[i] | adv[i+1]`, evaluated from the last stage down to stage 0.
  - `adv[i] = en[i]`.
- Stage enable without collapse: global stall, `en[i] = ~vld[LATENCY-1] | out_ready` for all i.
- `in_ready = en[0] & ~flush`.
- `stage_ce[i] = en[i] & ~flush`.
- On the clock edge, when `en[i]` is true: `vld[i] <= vld[i-1]`, with `vld[-1] = in_valid`.
- Input fire: `in_valid & in_ready`. Output fire: `out_valid & out_ready`.
- Occupancy update: `occupancy <= occupancy + in_fire - out_fire`.
  - The result never exceeds LATENCY and never goes negative by construction.
  - Simultaneous in fire and out fire leaves it unchanged.
- Flush has priority over all other updates:
  - During the flush cycle `in_ready`, `out_valid` and all `stage_ce` read 0.
  - Next edge: every `vld` becomes 0 and `occupancy` becomes 0.
  - An `in_valid` presented during flush is not accepted.
- Combinational paths exist from `out_ready` and `flush` to `in_ready` and `stage_ce`. Integrators register at the boundary when timing demands it.
- Reset (asynchronous, any time, including mid-stream): `vld` = 0, `occupancy` = 0. Outputs then read `in_ready`=1, `out_valid`=0, `vld_tap[1..]`=0, `stage_ce` all 1 (when `flush`=0).

## Timing
- Unstalled latency: a token accepted at edge t reaches `out_valid` after edge t+LATENCY-1 and is consumable in cycle t+LATENCY. This equals LATENCY register stages.
- Throughput is 1 token per cycle when `out_ready`=1.
- Stalled tokens hold in place; no token is ever dropped or duplicated.
- `vld_tap[i]` for i ≥ 1 is registered; `vld_tap[0]` is combinational.
- Reset release: the first accept can occur in the first cycle after `aresetn` deasserts.

## Configuration
- `HS_DPATH_VLD_CHAIN_COLLAPSE_EN` defined: per-stage enables. Empty stages keep accepting while the output stalls, so `in_ready` stays high until `occupancy` == LATENCY.
- Not defined: global-stall enables. Any `out_valid & ~out_ready` freezes the whole chain and drops `in_ready`, even if bubbles exist. This mode has a smaller enable cone.

## Test plan
- LATENCY=4, `in_valid`=1, `out_ready`=1 from reset -> first `out_valid` 4 cycles after the first accept; `in_ready` constantly 1; `occupancy` reaches 4 and holds.
- LATENCY=4, input pattern 1,0,1,0, then `out_ready`=0:
  - Collapse on -> `in_ready` stays 1 until `occupancy`=4, and `vld` packs to 1111 from the output end.
  - Collapse off -> `in_ready` drops the cycle `out_valid` rises, with `occupancy`=2.
- `occupancy`=3, one-cycle `flush` with `in_valid`=1 and `out_ready`=1 -> during flush `in_ready`=0, `out_valid`=0, `stage_ce`=0; next cycle `occupancy`=0 and all `vld_tap[1..4]`=0.
- Full chain (`occupancy`=4), `in_valid`=1, `out_ready`=1 -> in fire and out fire in the same cycle; `occupancy` stays 4.
- `aresetn` pulsed low mid-stream with `occupancy`=2 -> `out_valid`, `vld_tap[1..]` and `occupancy` read 0 before the next clock edge; accepts resume the cycle after release.
- LATENCY=1 -> `stage_ce[0]` equals `in_ready`; a token appears 1 cycle after accept; `occupancy` is a 1-bit value toggling 0/1 correctly.
